// File: rtl/tl_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
package tl_pkg;

    typedef enum logic [2:0] {
        ALLRED_P,
        GREEN_P,
        YELLOW_P,
        ALLRED_S,
        GREEN_S,
        YELLOW_S,
        BLINK
    } phase_e;

    // Lamp vector bit positions: {primary, secondary}.
    localparam int PRI = 1;
    localparam int SEC = 0;

    localparam int DEF_CW        = 4;
    localparam int DEF_MIN_GREEN = 6;
    localparam int DEF_MAX_GREEN = 15;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 1;
    localparam int DEF_WALK_T    = 4;

endpackage

// File: rtl/phase_timer.sv
// Tick-gated saturating phase timer with a "duration expires this tick" compare.
module phase_timer #(
    parameter int CW = 4
) (
    input  logic          Clock,
    input  logic          clear,
    input  logic          tick,
    input  logic [CW-1:0] dur,
    output logic [CW-1:0] count,
    output logic          expire
);

    always_ff @(posedge Clock) begin
        if (clear) begin
            count <= '0;
        end else if (tick && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

    // Duration D ends on the tick seen while the count sits at D-1.
    assign expire = tick && (count == (dur - CW'(1)));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer: FSM, pedestrian latch and lamp decode.
module intersection_phase_scheduler
    import tl_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       veh_s,
    input  logic       ped_req,
    input  logic       blink_en,
    output logic [1:0] red,
    output logic [1:0] yellow,
    output logic [1:0] green,
    output logic       walk,
    output logic       ped_pend
);

    phase_e        state;
    phase_e        nxt;
    logic          served;
    logic          blink_ph;
    logic [CW-1:0] timer;
    logic [CW-1:0] dur;
    logic          expire;
    logic          min_done;
    logic          walk_on;
    logic          enter_gs;

    always_comb begin
        dur = CW'(ALLRED_T);
        case (state)
            YELLOW_P, YELLOW_S: dur = CW'(YELLOW_T);
            GREEN_S:            dur = CW'(MAX_GREEN);
            default:            dur = CW'(ALLRED_T);
        endcase
    end

    phase_timer #(.CW(CW)) u_timer (
        .Clock  (Clock),
        .clear  (reset || (nxt != state)),
        .tick   (tick),
        .dur    (dur),
        .count  (timer),
        .expire (expire)
    );

    assign min_done = (timer >= CW'(MIN_GREEN));
    assign walk_on  = (state == GREEN_S) && served && (timer < CW'(WALK_T));
    assign enter_gs = (state != GREEN_S) && (nxt == GREEN_S);

    always_comb begin
        nxt = state;
        case (state)
            ALLRED_P: if (expire) nxt = GREEN_P;
            GREEN_P:  if (blink_en || (min_done && (veh_s || ped_pend))) nxt = YELLOW_P;
            YELLOW_P: if (expire) nxt = blink_en ? BLINK : ALLRED_S;
            ALLRED_S: if (expire) nxt = GREEN_S;
            GREEN_S:  if (blink_en || expire || (min_done && !veh_s && !walk_on)) nxt = YELLOW_S;
            YELLOW_S: if (expire) nxt = blink_en ? BLINK : ALLRED_P;
            BLINK:    if (!blink_en) nxt = ALLRED_P;
            default:  nxt = ALLRED_P;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state    <= ALLRED_P;
            ped_pend <= 1'b0;
            served   <= 1'b0;
            blink_ph <= 1'b0;
        end else begin
            state <= nxt;
            // A press on the entry cycle joins the walk about to start.
            if (enter_gs) begin
                ped_pend <= 1'b0;
                served   <= ped_pend || ped_req;
            end else if ((state != GREEN_S) && ped_req) begin
                ped_pend <= 1'b1;
            end
            if ((state == BLINK) && (nxt == BLINK)) begin
                blink_ph <= blink_ph ^ tick;
            end else begin
                blink_ph <= 1'b0;
            end
        end
    end

    // Lamps decode straight from flops, so they move on the same edge as the state.
    always_comb begin
        red    = 2'b00;
        yellow = 2'b00;
        green  = 2'b00;
        walk   = 1'b0;
        case (state)
            GREEN_P: begin
                green[PRI] = 1'b1;
                red[SEC]   = 1'b1;
            end
            YELLOW_P: begin
                yellow[PRI] = 1'b1;
                red[SEC]    = 1'b1;
            end
            GREEN_S: begin
                green[SEC] = 1'b1;
                red[PRI]   = 1'b1;
                walk       = walk_on;
            end
            YELLOW_S: begin
                yellow[SEC] = 1'b1;
                red[PRI]    = 1'b1;
            end
            BLINK: begin
                yellow[PRI] = blink_ph;
                red[SEC]    = blink_ph;
            end
            default: red = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed scenarios plus randomized traffic against a phase model.
module tb_intersection_phase_scheduler;

    localparam int CW        = 4;
    localparam int MIN_GREEN = 6;
    localparam int MAX_GREEN = 15;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 4;
    localparam int TMAX      = (1 << CW) - 1;

    localparam int M_ARP = 0, M_GP = 1, M_YP = 2, M_ARS = 3, M_GS = 4, M_YS = 5, M_BL = 6;

    logic       Clock;
    logic       reset;
    logic       tick;
    logic       veh_s;
    logic       ped_req;
    logic       blink_en;
    logic [1:0] red;
    logic [1:0] yellow;
    logic [1:0] green;
    logic       walk;
    logic       ped_pend;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    assign obs = {red, yellow, green, walk, ped_pend};

    intersection_phase_scheduler #(
        .CW(CW), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .Clock    (Clock),
        .reset    (reset),
        .tick     (tick),
        .veh_s    (veh_s),
        .ped_req  (ped_req),
        .blink_en (blink_en),
        .red      (red),
        .yellow   (yellow),
        .green    (green),
        .walk     (walk),
        .ped_pend (ped_pend)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: phase, ticks spent in it, pedestrian latch, served walk, blink ticks.
    int         m_ph = M_ARP;
    int         m_t = 0;
    int         m_bk = 0;
    bit         m_pend = 1'b0;
    bit         m_srv = 1'b0;
    logic [7:0] exp_q[$];

    function automatic int dur_of(int ph);
        case (ph)
            M_ARP, M_ARS: return ALLRED_T;
            M_YP, M_YS:   return YELLOW_T;
            M_GS:         return MAX_GREEN;
            default:      return -10;
        endcase
    endfunction

    function automatic logic [7:0] lamps(int ph, int t, bit pend, bit srv, int bk);
        logic [1:0] r, y, g;
        logic       w, b;
        r = 2'b00; y = 2'b00; g = 2'b00; w = 1'b0;
        b = ((bk % 2) == 1);
        case (ph)
            M_GP:    begin g = 2'b10; r = 2'b01; end
            M_YP:    begin y = 2'b10; r = 2'b01; end
            M_GS:    begin g = 2'b01; r = 2'b10; w = srv && (t < WALK_T); end
            M_YS:    begin y = 2'b01; r = 2'b10; end
            M_BL:    begin y = {b, 1'b0}; r = {1'b0, b}; end
            default: r = 2'b11;
        endcase
        return {r, y, g, w, pend};
    endfunction

    always @(posedge Clock) begin : model
        int np, nt, nbk;
        bit npend, nsrv, ex, wk;
        if (reset) begin
            np = M_ARP; nt = 0; npend = 1'b0; nsrv = 1'b0; nbk = 0;
        end else begin
            ex = tick && (m_t == dur_of(m_ph) - 1);
            wk = (m_ph == M_GS) && m_srv && (m_t < WALK_T);
            np = m_ph;
            case (m_ph)
                M_ARP: if (ex) np = M_GP;
                M_GP:  if (blink_en || (m_t >= MIN_GREEN && (veh_s || m_pend))) np = M_YP;
                M_YP:  if (ex) np = blink_en ? M_BL : M_ARS;
                M_ARS: if (ex) np = M_GS;
                M_GS:  if (blink_en || ex || (m_t >= MIN_GREEN && !veh_s && !wk)) np = M_YS;
                M_YS:  if (ex) np = blink_en ? M_BL : M_ARP;
                default: if (!blink_en) np = M_ARP;
            endcase
            if (np != m_ph) nt = 0;
            else nt = tick ? ((m_t + 1 > TMAX) ? TMAX : m_t + 1) : m_t;
            npend = m_pend;
            nsrv  = m_srv;
            if (np == M_GS && m_ph != M_GS) begin
                nsrv  = m_pend || ped_req;
                npend = 1'b0;
            end else if (m_ph != M_GS && ped_req) begin
                npend = 1'b1;
            end
            nbk = (m_ph == M_BL && np == M_BL) ? m_bk + int'(tick) : 0;
        end
        m_ph   <= np;
        m_t    <= nt;
        m_pend <= npend;
        m_srv  <= nsrv;
        m_bk   <= nbk;
        exp_q.push_back(lamps(np, nt, npend, nsrv, nbk));
    end

    // Scoreboard plus the lamp safety invariant, every cycle after the first reset edge.
    always @(negedge Clock) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lamps: got %b expected %b at %0t", obs, e, $time);
            end
            checks++;
            if ((green[1] && green[0]) || (green[1] && (!red[0] || yellow[0])) ||
                (green[0] && (!red[1] || yellow[1]))) begin
                errors++;
                $display("FAIL safety: red=%b yellow=%b green=%b, required no conflicting green at %0t",
                         red, yellow, green, $time);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; veh_s = 1'b0; ped_req = 1'b0; blink_en = 1'b0;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; veh_s = 1'b1; ped_req = 1'b1; blink_en = 1'b0;
        cyc(2);
        checks++;
        if (obs !== 8'b11_00_00_0_0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, 8'b11_00_00_0_0);
        end
        reset = 1'b0; tick = 1'b0; veh_s = 1'b0; ped_req = 1'b0;
    endtask

    task automatic test_green_hold();
        do_reset();
        tick = 1'b1;
        cyc(1);
        checks++;
        if (obs !== 8'b01_00_10_0_0) begin
            errors++;
            $display("FAIL green_p_entry: got %b expected %b", obs, 8'b01_00_10_0_0);
        end
        cyc(40);
        checks++;
        if (obs !== 8'b01_00_10_0_0) begin
            errors++;
            $display("FAIL green_p_hold: got %b expected %b", obs, 8'b01_00_10_0_0);
        end
        tick = 1'b0;
    endtask

    task automatic test_vehicle();
        int  gp_n, yp_n, ars_n, gs_n;
        bit  done;
        gp_n = 0; yp_n = 0; ars_n = 0; gs_n = 0; done = 1'b0;
        do_reset();
        tick = 1'b1;
        cyc(3);
        veh_s = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc(1);
            case ({red, yellow, green})
                6'b01_00_10: gp_n++;
                6'b01_10_00: yp_n++;
                6'b11_00_00: ars_n++;
                6'b10_00_01: gs_n++;
                6'b10_01_00: done = 1'b1;
                default: ;
            endcase
        end
        checks++;
        if (!done) begin errors++; $display("FAIL veh_timeout: YELLOW_S not reached within 60 cycles"); end
        checks++;
        if (gp_n != 4) begin errors++; $display("FAIL veh_green_p_rest: got %0d expected 4", gp_n); end
        checks++;
        if (yp_n != YELLOW_T) begin errors++; $display("FAIL veh_yellow_p: got %0d expected %0d", yp_n, YELLOW_T); end
        checks++;
        if (ars_n != ALLRED_T) begin errors++; $display("FAIL veh_allred_s: got %0d expected %0d", ars_n, ALLRED_T); end
        checks++;
        if (gs_n != MAX_GREEN) begin errors++; $display("FAIL veh_max_green: got %0d expected %0d", gs_n, MAX_GREEN); end
        veh_s = 1'b0;
    endtask

    task automatic test_ped();
        int gs_n, walk_n, pend_gs;
        bit done;
        gs_n = 0; walk_n = 0; pend_gs = 0; done = 1'b0;
        do_reset();
        tick = 1'b1;
        cyc(1);
        ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
        checks++;
        if (ped_pend !== 1'b1) begin errors++; $display("FAIL ped_latch: got %b expected 1", ped_pend); end
        for (int i = 0; i < 60 && !done; i++) begin
            cyc(1);
            if (green == 2'b01) begin
                gs_n++;
                if (walk) walk_n++;
                if (ped_pend) pend_gs++;
            end
            if (yellow == 2'b01) done = 1'b1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL ped_timeout: YELLOW_S not reached within 60 cycles"); end
        checks++;
        if (walk_n != WALK_T) begin errors++; $display("FAIL ped_walk_len: got %0d expected %0d", walk_n, WALK_T); end
        checks++;
        if (gs_n != MIN_GREEN + 1) begin errors++; $display("FAIL ped_green_s_len: got %0d expected %0d", gs_n, MIN_GREEN + 1); end
        checks++;
        if (pend_gs != 0) begin errors++; $display("FAIL ped_pend_in_gs: got %0d cycles expected 0", pend_gs); end
    endtask

    task automatic test_blink();
        bit found;
        found = 1'b0;
        do_reset();
        tick = 1'b1; veh_s = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (green == 2'b01) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL blink_timeout: GREEN_S not reached within 60 cycles"); end
        cyc(2);
        blink_en = 1'b1;
        cyc(1);
        checks++;
        if (obs !== 8'b10_01_00_0_0) begin errors++; $display("FAIL blink_to_yellow_s: got %b expected %b", obs, 8'b10_01_00_0_0); end
        cyc(YELLOW_T);
        checks++;
        if (obs !== 8'b00_00_00_0_0) begin errors++; $display("FAIL blink_entry: got %b expected %b", obs, 8'b00_00_00_0_0); end
        for (int k = 1; k <= 6; k++) begin
            logic [7:0] e;
            cyc(1);
            e = (k % 2 == 1) ? 8'b01_10_00_0_0 : 8'b00_00_00_0_0;
            checks++;
            if (obs !== e) begin errors++; $display("FAIL blink_toggle_%0d: got %b expected %b", k, obs, e); end
        end
        blink_en = 1'b0; veh_s = 1'b0;
        cyc(1);
        checks++;
        if (obs !== 8'b11_00_00_0_0) begin errors++; $display("FAIL blink_exit: got %b expected %b", obs, 8'b11_00_00_0_0); end
        cyc(1);
        checks++;
        if (obs !== 8'b01_00_10_0_0) begin errors++; $display("FAIL blink_to_green_p: got %b expected %b", obs, 8'b01_00_10_0_0); end
    endtask

    task automatic test_ped_entry();
        bit seen_y, found;
        int walk_n;
        seen_y = 1'b0; found = 1'b0; walk_n = 0;
        do_reset();
        tick = 1'b1; veh_s = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (yellow == 2'b10) seen_y = 1'b1;
            if (seen_y && red == 2'b11) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL entry_timeout: ALLRED_S not reached within 60 cycles"); end
        ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
        checks++;
        if (obs !== 8'b10_00_01_1_0) begin errors++; $display("FAIL entry_press: got %b expected %b", obs, 8'b10_00_01_1_0); end
        walk_n = walk ? 1 : 0;
        repeat (10) begin
            cyc(1);
            if (walk) walk_n++;
        end
        checks++;
        if (walk_n != WALK_T) begin errors++; $display("FAIL entry_walk_len: got %0d expected %0d", walk_n, WALK_T); end
        veh_s = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        do_reset();
        tick = 1'b1; veh_s = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (yellow == 2'b01) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rmid_timeout: YELLOW_S not reached within 60 cycles"); end
        tick = 1'b0; ped_req = 1'b1;
        cyc(1);
        ped_req = 1'b0;
        checks++;
        if (obs !== 8'b10_01_00_0_1) begin errors++; $display("FAIL rmid_pend: got %b expected %b", obs, 8'b10_01_00_0_1); end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++;
        if (obs !== 8'b11_00_00_0_0) begin errors++; $display("FAIL rmid_reset: got %b expected %b", obs, 8'b11_00_00_0_0); end
        cyc(2);
        checks++;
        if (obs !== 8'b11_00_00_0_0) begin errors++; $display("FAIL rmid_hold: got %b expected %b", obs, 8'b11_00_00_0_0); end
        tick = 1'b1;
        cyc(1);
        checks++;
        if (obs !== 8'b01_00_10_0_0) begin errors++; $display("FAIL rmid_restart: got %b expected %b", obs, 8'b01_00_10_0_0); end
        veh_s = 1'b0; tick = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick    = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) veh_s = $urandom_range(0, 1);
            if ($urandom_range(0, 119) == 0) blink_en = ~blink_en;
            reset = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        reset = 1'b0; tick = 1'b0; veh_s = 1'b0; ped_req = 1'b0; blink_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; veh_s = 1'b0; ped_req = 1'b0; blink_en = 1'b0;
        test_reset();
        test_green_hold();
        test_vehicle();
        test_ped();
        test_blink();
        test_ped_entry();
        test_reset_mid();
        test_random();
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Tick-timed phase sequencer for a two-road intersection, primary and secondary.
- Arbitrates right-of-way between primary traffic, secondary vehicle demand and a pedestrian crossing request.
- Enforces minimum and maximum green, yellow and all-red clearance, and supports a blink (night) mode.
- Drives the per-road red/yellow/green lamp outputs, with bit 1 = primary and bit 0 = secondary, plus a walk lamp.

Parameters:
- CW, 4: timer width in bits; every duration parameter must be < 2^CW.
- MIN_GREEN, 6: ticks of green before a demand-driven exit is allowed.
- MAX_GREEN, 15: ticks after which secondary green ends unconditionally.
- YELLOW_T, 3: yellow duration in ticks.
- ALLRED_T, 1: all-red clearance duration in ticks.
- WALK_T, 4: walk duration in ticks, taken from the start of GREEN_S.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle timebase strobe; all timers count only on tick=1.
- veh_s  input  1  secondary-road vehicle sensor, level.
- ped_req  input  1  pedestrian button (crossing the primary road), pulse or level.
- blink_en  input  1  blink/night-mode request, level.
- red  output  2  red lamps {primary, secondary}.
- yellow  output  2  yellow lamps {primary, secondary}.
- green  output  2  green lamps {primary, secondary}.
- walk  output  1  pedestrian walk lamp.
- ped_pend  output  1  pedestrian request latched and not yet served.

Behaviour:
- Reset (synchronous, overrides all other inputs):
  - state=ALLRED_P, timer=0, ped_pend=0, blink phase=0.
  - red=2'b11, yellow=2'b00, green=2'b00, walk=0.
- Outputs are a Moore decode of the state register, so they change on the same edge as the state.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick and saturates at 2^CW-1.
  - "Duration D expires" means tick=1 while timer==D-1.
- States and lamps:
  - ALLRED_P (red=11): when ALLRED_T expires -> GREEN_P.
  - GREEN_P (green=10, red=01):
    - -> YELLOW_P when blink_en=1, immediately; min green is ignored.
    - -> YELLOW_P when timer>=MIN_GREEN and (veh_s or ped_pend). This exit is not tick-gated.
    - With no demand, GREEN_P holds indefinitely.
  - YELLOW_P (yellow=10, red=01): when YELLOW_T expires -> BLINK if blink_en, else ALLRED_S.
  - ALLRED_S (red=11): when ALLRED_T expires -> GREEN_S.
  - GREEN_S (green=01, red=10):
    - -> YELLOW_S when blink_en=1, immediately.
    - -> YELLOW_S when timer>=MIN_GREEN and veh_s=0 and walk=0.
    - -> YELLOW_S when MAX_GREEN expires, regardless of demand.
  - YELLOW_S (yellow=01, red=10): when YELLOW_T expires -> BLINK if blink_en, else ALLRED_P.
  - BLINK:
    - green=00, walk=0.
    - yellow[1] and red[0] both equal the blink phase; all other lamps are off.
    - The blink phase toggles on every tick.
    - On blink_en=0 -> ALLRED_P, with blink phase cleared.
- blink_en asserted in ALLRED_P or ALLRED_S: the clearance completes first, then the next GREEN state is entered and exits to yellow on the following cycle.
- Pedestrian:
  - ped_pend sets on ped_req=1 in any state except GREEN_S.
  - ped_pend clears on the cycle GREEN_S is entered. A press on that entry cycle is absorbed and served by this walk.
  - A press during GREEN_S is ignored.
  - walk=1 in GREEN_S while timer<WALK_T, but only if ped_pend was set at entry; this is captured in a served flag.
  - ped_pend is held through BLINK.
- Safety invariant: never green[1]&green[0], and never a green together with the other road's non-red. Bench asserts this every cycle.
- Simultaneous events in GREEN_S: MAX_GREEN expiry and blink_en together both go to YELLOW_S, with no conflict.

Decomposition:
- Shared package tl_pkg holds:
  - phase_e enum: ALLRED_P, GREEN_P, YELLOW_P, ALLRED_S, GREEN_S, YELLOW_S, BLINK.
  - Lamp-bit localparams: PRI=1, SEC=0.
  - Default duration constants.
- One natural sub-module, phase_timer: clear, tick-gated saturating counter, and a "timer==D-1 && tick" expire compare.
- The FSM, pedestrian latch and lamp decode stay in the top.

Test Plan:
- Reset, then 1 tick -> GREEN_P: green=10, red=01. Hold 40 ticks with no demand -> still GREEN_P.
- veh_s=1 at GREEN_P timer=2:
  - Exit at timer=6 -> YELLOW_P for 3 ticks, then ALLRED_S for 1 tick, then GREEN_S.
  - veh_s held -> GREEN_S lasts exactly 15 ticks, then YELLOW_S.
- ped_req single-cycle pulse in GREEN_P with veh_s=0:
  - ped_pend=1 and YELLOW_P follows after min green.
  - In GREEN_S, walk=1 for ticks 0-3 and ped_pend=0.
  - GREEN_S exits at timer=6.
- blink_en=1 at GREEN_S timer=2:
  - YELLOW_S on the next cycle, 3 ticks, then BLINK with yellow[1]/red[0] toggling each tick.
  - Deassert blink_en -> ALLRED_P, then GREEN_P.
- ped_req asserted on the exact cycle GREEN_S is entered -> ped_pend stays 0 and walk=1 for 4 ticks.
- reset=1 mid-YELLOW_S with ped_pend=1 -> next cycle red=11, walk=0, ped_pend=0, timer=0.
